act_requant_pack: RTL and testbench
===================================

# act_requant_pack

Downstream companion to the sequential dot-product PE. It accepts one signed accumulator result per transfer, applies rounding right-shift, optional ReLU and saturation to W bits, and packs NUM_OUT such results into a flat output vector. That vector is the `in_vector_flat` operand of the next layer's PEs. It bridges the PE's held `done`/`result` pair to a valid/ready vector handshake.

## Interface
- NUM_OUT, 16, results collected per output vector (≥2)
- W, 8, output element width (signed)
- ACC_WIDTH, 15, input result width (signed), must be > W
- SHIFT, 4, requant arithmetic right shift (0..ACC_WIDTH-1)
- RELU, 1, 1 = clamp negatives to 0
- EDGE_MODE, 1, 1 = accept on rising edge of in_valid (for a held done level); 0 = accept every cycle in_valid && in_ready

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- clear  input  1  synchronous discard of partial/full vector
- in_valid  input  1  result qualifier (PE done)
- in_data  input  ACC_WIDTH  signed PE result
- in_ready  output  1  block can accept
- out_valid  output  1  packed vector available
- out_ready  input  1  consumer takes vector
- out_vector_flat  output  W*NUM_OUT  element k at bits [k*W +: W]
- count  output  $clog2(NUM_OUT+1)  elements stored
- drop_err  output  1  sticky: input event lost while not ready

## Operation
- States: COLLECT (in_ready=1), FULL (in_ready=0, out_valid=1).
- Accept event:
  - EDGE_MODE=1: in_valid && !prev_valid && in_ready.
  - EDGE_MODE=0: in_valid && in_ready.
  - prev_valid is a register of in_valid and updates every cycle regardless of state.
- On accept, element index = count; count increments.
- On the accept that makes count == NUM_OUT, go to FULL.
- FULL: out_vector_flat and count are held stable until out_valid && out_ready. Then count ← 0 and state ← COLLECT.
- Event qualifier without in_ready (FULL): not stored, drop_err ← 1.
- Arithmetic, computed in ACC_WIDTH+1 bits:
  1. r = (in_data + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (round half up, arithmetic shift).
  2. If RELU and r<0, r ← 0.
  3. Saturate to [-2^(W-1), 2^(W-1)-1].
  4. Store low W bits.
- Priority: reset > clear > output handshake > accept.
- clear: count ← 0, state COLLECT, vector ← 0, drop_err ← 0. An input event in the same cycle is ignored. prev_valid still updates.

## Timing
- Reset values: in_ready=1 (COLLECT), out_valid=0, out_vector_flat=0, count=0, drop_err=0, prev_valid=0.
- Accept in cycle t: element and count visible at t+1.
- Final accept in cycle t: out_valid=1 and in_ready=0 at t+1.
- Output handshake in cycle t: out_valid=0, in_ready=1, count=0 at t+1.
- No accept is possible in the handshake cycle, which gives one bubble per vector.
- out_vector_flat keeps its old contents after the handshake. Slots are overwritten as new elements arrive.
- EDGE_MODE=1: a level held across the handshake does not re-trigger. A new rising edge is required.
- Reset or clear mid-collection: the partial vector is lost, with no output.

## Structure
- Shared package:
  - State encoding localparams (COLLECT, FULL).
  - Saturation bounds helper constants, derived from W.
  - Requant function (round/shift/relu/saturate).
- One sub-module is natural: `requant_sat`, combinational, ACC_WIDTH→W with SHIFT and RELU parameters. It can be reused by later stages.
- The top holds the FSM, counter, edge detector and element register array, which is written by index decode.

## Test plan
- Defaults, 16 pulses with in_data=24 each → out_valid 1 cycle after the 16th accept; every element = 2 (24+8=32>>4); count=16.
- RELU=1, in_data=-24 → element 0. RELU=0, same input → element -1 (0xFF).
- in_data=3000 → 127 (0x7F). RELU=0, in_data=-3000 → -128 (0x80).
- EDGE_MODE=1, in_valid held high for 5 cycles → exactly one element stored. Vector full with out_ready=0 and a new edge arriving → not stored, drop_err=1, vector unchanged.
- out_ready held high at fill → out_valid high for exactly 1 cycle. Next accept possible 2 cycles after the fill cycle.
- clear asserted after 7 accepts, simultaneous with an edge → count=0, vector zero, drop_err=0. The following 16 accepts produce a clean vector.

Source files
------------

// File: rtl/act_requant_pack_pkg.sv
// Shared types and arithmetic helpers for the accumulator requantise/pack stage.
package act_requant_pack_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    function automatic int sat_hi(input int w);
        return (1 <<< (w - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int w);
        return -(1 <<< (w - 1));
    endfunction

    localparam int W_DEF      = 8;
    localparam int SAT_HI_DEF = sat_hi(W_DEF);
    localparam int SAT_LO_DEF = sat_lo(W_DEF);

    // Round half up, arithmetic shift, optional ReLU, saturate; 32-bit headroom covers ACC_WIDTH+1.
    function automatic int requant(input int x, input int shift, input bit relu, input int w);
        int r;
        r = x;
        if (shift > 0) r = x + (1 <<< (shift - 1));
        r = r >>> shift;
        if (relu && r < 0) r = 0;
        if (r > sat_hi(w))      r = sat_hi(w);
        else if (r < sat_lo(w)) r = sat_lo(w);
        return r;
    endfunction

endpackage

// File: rtl/act_requant_pack_requant_sat.sv
// Combinational requantiser: signed ACC_WIDTH accumulator down to a saturated W-bit element.
module requant_sat
    import act_requant_pack_pkg::*;
#(
    parameter int ACC_WIDTH = 15,
    parameter int W         = 8,
    parameter int SHIFT     = 4,
    parameter int RELU      = 1
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic        [W-1:0]         q_o
);

    assign q_o = W'(requant(int'(acc_i), SHIFT, RELU != 0, W));

endmodule

// File: rtl/act_requant_pack.sv
// Collects NUM_OUT requantised PE results into a flat vector with a valid/ready output.
module act_requant_pack
    import act_requant_pack_pkg::*;
#(
    parameter int NUM_OUT   = 16,
    parameter int W         = 8,
    parameter int ACC_WIDTH = 15,
    parameter int SHIFT     = 4,
    parameter int RELU      = 1,
    parameter int EDGE_MODE = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic signed [ACC_WIDTH-1:0]   in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W*NUM_OUT-1:0]          out_vector_flat,
    output logic [$clog2(NUM_OUT+1)-1:0]  count,
    output logic                          drop_err
);

    localparam int CW = $clog2(NUM_OUT + 1);

    state_e                       state_q;
    logic [CW-1:0]                cnt_q;
    logic [NUM_OUT-1:0][W-1:0]    vec_q, vec_d;
    logic                         prev_q;
    logic                         drop_q;
    logic [W-1:0]                 elem;
    logic                         evt;
    logic                         accept;

    requant_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .W         (W),
        .SHIFT     (SHIFT),
        .RELU      (RELU)
    ) u_rq (
        .acc_i (in_data),
        .q_o   (elem)
    );

    // A held PE done level counts once; prev_q tracks in_valid in every state.
    assign evt    = (EDGE_MODE != 0) ? (in_valid && !prev_q) : in_valid;
    assign accept = evt && in_ready;

    assign in_ready        = (state_q == COLLECT);
    assign out_valid       = (state_q == FULL);
    assign out_vector_flat = vec_q;
    assign count           = cnt_q;
    assign drop_err        = drop_q;

    always_comb begin
        vec_d = vec_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (accept && cnt_q == CW'(k)) vec_d[k] = elem;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            vec_q   <= '0;
            prev_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            prev_q <= in_valid;
            if (clear) begin
                state_q <= COLLECT;
                cnt_q   <= '0;
                vec_q   <= '0;
                drop_q  <= 1'b0;
            end else begin
                vec_q <= vec_d;
                case (state_q)
                    COLLECT: begin
                        if (evt) begin
                            cnt_q <= cnt_q + CW'(1);
                            if (cnt_q == CW'(NUM_OUT - 1)) state_q <= FULL;
                        end
                    end
                    FULL: begin
                        // Handshake cycle is still FULL, so an event here is lost too.
                        if (out_ready) begin
                            cnt_q   <= '0;
                            state_q <= COLLECT;
                        end
                        if (evt) drop_q <= 1'b1;
                    end
                    default: state_q <= COLLECT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_act_requant_pack.sv
// Scoreboard bench: expected vectors are queued at stimulus time and popped on each output handshake.
module tb_act_requant_pack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // DUT A: defaults (NUM_OUT=16, RELU=1, EDGE_MODE=1)
    logic               a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_drop;
    logic signed [14:0] a_in_data;
    logic [127:0]       a_vec;
    logic [4:0]         a_count;

    // DUT B: NUM_OUT=4, RELU=0, level mode
    logic               b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_drop;
    logic signed [14:0] b_in_data;
    logic [31:0]        b_vec;
    logic [2:0]         b_count;

    act_requant_pack dut_a (
        .clk(clk), .reset(reset), .clear(a_clear), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_vector_flat(a_vec), .count(a_count), .drop_err(a_drop)
    );

    act_requant_pack #(.NUM_OUT(4), .RELU(0), .EDGE_MODE(0)) dut_b (
        .clk(clk), .reset(reset), .clear(b_clear), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_vector_flat(b_vec), .count(b_count), .drop_err(b_drop)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [127:0] qa[$];
    logic [31:0]  qb[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input int d);
        a_in_data  = 15'(d);
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        step();
    endtask

    // Monitors: compare whenever a vector is actually handed off
    always @(negedge clk) begin
        if (!reset && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                n_chk++;
                $display("FAIL a_unexpected_vec: got %0h expected no vector", a_vec);
            end else begin
                chk("a_vec", a_vec, qa.pop_front());
                chk("a_count_full", a_count, 128'd16);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_chk++;
                $display("FAIL b_unexpected_vec: got %0h expected no vector", b_vec);
            end else begin
                chk("b_vec", b_vec, qb.pop_front());
                chk("b_count_full", b_count, 128'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] ev;

        reset = 1'b1;
        a_clear = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_clear = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 1;
        repeat (3) step();
        reset = 1'b0;

        chk("a_rst_in_ready",  a_in_ready,  1);
        chk("a_rst_out_valid", a_out_valid, 0);
        chk("a_rst_vec",       a_vec,       0);
        chk("a_rst_count",     a_count,     0);
        chk("a_rst_drop",      a_drop,      0);
        chk("b_rst_in_ready",  b_in_ready,  1);
        chk("b_rst_out_valid", b_out_valid, 0);

        // 16 x 24 -> every element (24+8)>>4 = 2
        qa.push_back({16{8'h02}});
        for (int i = 0; i < 15; i++) pulse_a(24);
        chk("a_count_15",  a_count,     15);
        chk("a_not_full",  a_out_valid, 0);
        a_in_data = 15'(24); a_in_valid = 1'b1;
        step();
        chk("a_fill_valid", a_out_valid, 1);
        chk("a_fill_ready", a_in_ready,  0);
        chk("a_fill_count", a_count,     16);
        a_in_valid = 1'b0;
        step();

        // New edge while full and not drained
        a_in_data = 15'(100); a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        chk("a_drop_set",      a_drop,      1);
        chk("a_drop_vec_hold", a_vec,       {16{8'h02}});
        chk("a_drop_cnt_hold", a_count,     16);
        chk("a_drop_still_full", a_out_valid, 1);

        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        chk("a_hs_valid",    a_out_valid, 0);
        chk("a_hs_ready",    a_in_ready,  1);
        chk("a_hs_count",    a_count,     0);
        chk("a_hs_vec_keep", a_vec,       {16{8'h02}});
        chk("a_hs_drop_sticky", a_drop,   1);

        // ReLU clamp and positive saturation
        pulse_a(-24);
        chk("a_relu_count", a_count,   1);
        chk("a_relu_elem",  a_vec[7:0], 8'h00);
        pulse_a(3000);
        chk("a_sat_hi_elem", a_vec[15:8], 8'h7F);

        // Level held 5 cycles stores once: (40+8)>>4 = 3
        a_in_data = 15'(40); a_in_valid = 1'b1;
        repeat (5) step();
        a_in_valid = 1'b0;
        step();
        chk("a_held_count", a_count, 3);
        chk("a_held_vec",   a_vec,   {{13{8'h02}}, 8'h03, 8'h7F, 8'h00});

        // Clear after 7 accepts, coincident with an edge
        for (int i = 0; i < 4; i++) pulse_a(24);
        chk("a_count_7", a_count, 7);
        a_clear = 1'b1; a_in_data = 15'(24); a_in_valid = 1'b1;
        step();
        a_clear = 1'b0; a_in_valid = 1'b0;
        chk("a_clr_count", a_count,    0);
        chk("a_clr_vec",   a_vec,      0);
        chk("a_clr_drop",  a_drop,     0);
        chk("a_clr_ready", a_in_ready, 1);
        step();

        // Clean vector: element k from 16k -> k; drain on the fill edge
        for (int k = 0; k < 16; k++) ev[k*8 +: 8] = 8'(k);
        qa.push_back(ev);
        a_out_ready = 1'b1;
        for (int k = 0; k < 15; k++) pulse_a(16 * k);
        a_in_data = 15'(240); a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        chk("a2_fill_valid", a_out_valid, 1);
        step();
        chk("a2_one_cycle_valid", a_out_valid, 0);
        chk("a2_hs_count",        a_count,     0);
        chk("a2_hs_ready",        a_in_ready,  1);
        a_in_data = 15'(24); a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        chk("a2_next_accept_cnt",  a_count,    1);
        chk("a2_next_accept_elem", a_vec[7:0], 8'h02);
        step();

        // B: level mode, no ReLU: -24->FF, -3000->80, 3000->7F, 24->02
        qb.push_back(32'h027F_80FF);
        b_in_valid = 1'b1;
        b_in_data = -15'sd24;   step();
        b_in_data = -15'sd3000; step();
        b_in_data = 15'sd3000;  step();
        b_in_data = 15'sd24;    step();
        b_in_valid = 1'b0;
        chk("b_fill_valid", b_out_valid, 1);
        chk("b_fill_count", b_count,     4);
        step();
        chk("b_hs_valid", b_out_valid, 0);
        chk("b_hs_count", b_count,     0);

        // Rounding at the half boundaries: -8->0, -9->FF, 8->1, 7->0
        qb.push_back(32'h0001_FF00);
        b_in_valid = 1'b1;
        b_in_data = -15'sd8; step();
        b_in_data = -15'sd9; step();
        b_in_data = 15'sd8;  step();
        b_in_data = 15'sd7;  step();
        b_in_valid = 1'b0;
        step();
        chk("b_no_drop", b_drop, 0);

        repeat (3) step();
        chk("a_sb_empty", qa.size(), 0);
        chk("b_sb_empty", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
